// File: rtl/systolic_out_pkg.sv
// Shared types and helpers for the systolic output write path: FSM encoding,
// bank rotation and the address where tail rows begin.
package systolic_out_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_t;

    // Head bank of a data set; the tail bank is the following one, modulo the bank count.
    function automatic int bank_of(input int set_id, input int num_banks);
        return set_id % num_banks;
    endfunction

    // Tail rows start right after the ARRAY_SIZE head rows.
    function automatic int tail_base(input int array_size);
        return array_size;
    endfunction

endpackage

// File: rtl/write_lane_align.sv
// Combinational de-skew of one anti-diagonal beat into an SRAM row:
// head beats keep lanes 0..k, tail beats drop the first j+1 lanes; the row is lane-reversed.
module write_lane_align #(
    parameter int ARRAY_SIZE        = 32,
    parameter int OUTPUT_DATA_WIDTH = 16,
    parameter int ADDR_W            = 6
) (
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] beat,
    input  logic [ADDR_W-1:0]                       k,
    input  logic                                    is_tail,
    output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] row
);

    localparam int W = OUTPUT_DATA_WIDTH;

    logic [ARRAY_SIZE*W-1:0] src;
    int                      shamt;

    // Tail beat j = k-ARRAY_SIZE: shifting out j+1 lanes also zero-fills the vacated top lanes.
    assign shamt = (int'(k) - ARRAY_SIZE + 1) * W;

    always_comb begin
        src = '0;
        row = '0;
        if (is_tail) begin
            src = beat >> shamt;
        end else begin
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                if (i <= int'(k)) src[i*W +: W] = beat[i*W +: W];
            end
        end
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            row[(ARRAY_SIZE-1-i)*W +: W] = src[i*W +: W];
        end
    end

endmodule

// File: rtl/systolic_write_scheduler.sv
// De-skews anti-diagonal systolic output beats into rotating SRAM banks, with a
// start/busy/done handshake, a diagonal counter and a sticky protocol error flag.
module systolic_write_scheduler
    import systolic_out_pkg::*;
#(
    parameter int ARRAY_SIZE        = 32,
    parameter int OUTPUT_DATA_WIDTH = 16,
    parameter int NUM_BANKS         = 3,
    parameter int SET_W             = 2,
    parameter int ADDR_W            = 6
) (
    input  logic                                    clk,
    input  logic                                    srstn,
    input  logic                                    start,
    input  logic [SET_W-1:0]                        set_id,
    input  logic                                    in_valid,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] quantized_data,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    err,
    output logic [NUM_BANKS-1:0]                    sram_we_n,
    output logic [ADDR_W-1:0]                       sram_waddr,
    output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_wdata
);

    localparam int ROW_W  = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [ADDR_W-1:0] TAIL_K = ADDR_W'(tail_base(ARRAY_SIZE));
    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(2 * ARRAY_SIZE - 2);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   k, k_nxt;
    logic [BANK_W-1:0]   hb, tb, hb_nxt, tb_nxt, wr_bank;
    logic                wr, is_tail, last_beat, err_set;
    logic [NUM_BANKS-1:0] we_n_nxt;
    logic [ROW_W-1:0]    row;

    logic [NUM_BANKS-1:0] we_n_p1;
    logic [ADDR_W-1:0]    waddr_p1;
    logic [ROW_W-1:0]     wdata_p1;
    logic                 busy_p1, done_p1, err_p1;

    assign wr        = (state == ST_RUN) && in_valid;
    assign is_tail   = (k >= TAIL_K);
    assign last_beat = (k == LAST_K);
    assign wr_bank   = is_tail ? tb : hb;

    write_lane_align #(
        .ARRAY_SIZE        (ARRAY_SIZE),
        .OUTPUT_DATA_WIDTH (OUTPUT_DATA_WIDTH),
        .ADDR_W            (ADDR_W)
    ) u_align (
        .beat    (quantized_data),
        .k       (k),
        .is_tail (is_tail),
        .row     (row)
    );

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        hb_nxt    = hb;
        tb_nxt    = tb;
        err_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                // A beat arriving with start is still dropped: the set has not begun yet.
                err_set = in_valid;
                if (start) begin
                    state_nxt = ST_RUN;
                    k_nxt     = '0;
                    hb_nxt    = BANK_W'(bank_of(int'(set_id), NUM_BANKS));
                    tb_nxt    = BANK_W'(bank_of(int'(set_id) + 1, NUM_BANKS));
                end
            end
            ST_RUN: begin
                err_set = start;
                if (wr) begin
                    k_nxt = k + ADDR_W'(1);
                    if (last_beat) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                err_set   = start;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        we_n_nxt = '1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (wr && (wr_bank == BANK_W'(b))) we_n_nxt[b] = 1'b0;
        end
    end

    // Stage p1: registered SRAM write port and status, one cycle after the accepted beat.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state    <= ST_IDLE;
            k        <= '0;
            hb       <= '0;
            tb       <= '0;
            we_n_p1  <= '1;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
            busy_p1  <= 1'b0;
            done_p1  <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            state    <= state_nxt;
            k        <= k_nxt;
            hb       <= hb_nxt;
            tb       <= tb_nxt;
            we_n_p1  <= we_n_nxt;
            waddr_p1 <= wr ? k : '0;
            wdata_p1 <= wr ? row : '0;
            busy_p1  <= (state_nxt != ST_IDLE);
            done_p1  <= wr && last_beat;
            err_p1   <= err_p1 | err_set;
        end
    end

    assign sram_we_n  = we_n_p1;
    assign sram_waddr = waddr_p1;
    assign sram_wdata = wdata_p1;
    assign busy       = busy_p1;
    assign done       = done_p1;
    assign err        = err_p1;

endmodule

// File: tb/tb_systolic_write_scheduler.sv
// Bench for systolic_write_scheduler: a small 4x4/8-bit/3-bank instance for directed
// scenarios and a 32x32/16-bit/4-bank instance for randomized full sets, both checked every cycle.
module tb_systolic_write_scheduler;

    localparam int SA = 4,  SW = 8,  SN = 3;
    localparam int LA = 32, LW = 16, LN = 4;

    logic         clk = 1'b0;
    logic         srstn, start, in_valid, sel;
    logic [1:0]   set_id;
    logic [511:0] qd;

    logic [2:0]   s_we_n, s_waddr;
    logic [31:0]  s_wdata;
    logic         s_busy, s_done, s_err;
    logic [3:0]   l_we_n;
    logic [5:0]   l_waddr;
    logic [511:0] l_wdata;
    logic         l_busy, l_done, l_err;

    logic [3:0]   o_we_n;
    logic [5:0]   o_waddr;
    logic [511:0] o_wdata;
    logic         o_busy, o_done, o_err;

    int   checks = 0, errors = 0;
    int   ph = 0, mk = 0, mset = 0, writes = 0;
    logic m_err_s = 1'b0, m_err_l = 1'b0;

    always #5 clk = ~clk;

    systolic_write_scheduler #(.ARRAY_SIZE(SA), .OUTPUT_DATA_WIDTH(SW), .NUM_BANKS(SN),
                               .SET_W(2), .ADDR_W(3)) dut_s (
        .clk(clk), .srstn(srstn), .start(start & ~sel), .set_id(set_id),
        .in_valid(in_valid & ~sel), .quantized_data(qd[31:0]),
        .busy(s_busy), .done(s_done), .err(s_err),
        .sram_we_n(s_we_n), .sram_waddr(s_waddr), .sram_wdata(s_wdata));

    systolic_write_scheduler #(.ARRAY_SIZE(LA), .OUTPUT_DATA_WIDTH(LW), .NUM_BANKS(LN),
                               .SET_W(2), .ADDR_W(6)) dut_l (
        .clk(clk), .srstn(srstn), .start(start & sel), .set_id(set_id),
        .in_valid(in_valid & sel), .quantized_data(qd),
        .busy(l_busy), .done(l_done), .err(l_err),
        .sram_we_n(l_we_n), .sram_waddr(l_waddr), .sram_wdata(l_wdata));

    assign o_we_n  = sel ? l_we_n  : {1'b1, s_we_n};
    assign o_waddr = sel ? l_waddr : {3'b000, s_waddr};
    assign o_wdata = sel ? l_wdata : {480'd0, s_wdata};
    assign o_busy  = sel ? l_busy  : s_busy;
    assign o_done  = sel ? l_done  : s_done;
    assign o_err   = sel ? l_err   : s_err;

    // Expected row: output slot s holds the lane that belongs to SRAM column s of this diagonal.
    function automatic logic [511:0] exp_row(input logic [511:0] beat, input int k,
                                             input int a, input int w);
        logic [511:0] r = '0;
        for (int s = 0; s < a; s++) begin
            int lane = -1;
            if (k < a) begin
                if (a - 1 - s <= k) lane = a - 1 - s;
            end else if (s > k - a) begin
                lane = k - s;
            end
            if (lane >= 0)
                for (int b = 0; b < w; b++) r[s*w + b] = beat[lane*w + b];
        end
        return r;
    endfunction

    function automatic logic [511:0] rnd_beat();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst_n, input logic st, input logic [1:0] sid,
                        input logic iv, input logic [511:0] d);
        logic [3:0]   e_we_n = '1;
        logic [5:0]   e_addr = '0;
        logic [511:0] e_data = '0;
        logic         e_done = 1'b0;
        int a, w, n, bank;
        a = sel ? LA : SA;
        w = sel ? LW : SW;
        n = sel ? LN : SN;
        srstn = rst_n; start = st; set_id = sid; in_valid = iv; qd = d;
        if (!rst_n) begin
            ph = 0; mk = 0; m_err_s = 1'b0; m_err_l = 1'b0;
        end else begin
            if ((ph == 0 && iv) || (ph != 0 && st)) begin
                if (sel) m_err_l = 1'b1; else m_err_s = 1'b1;
            end
            if (ph == 1 && iv) begin
                bank = ((mset % n) + (mk >= a ? 1 : 0)) % n;
                e_we_n[bank] = 1'b0;
                e_addr = 6'(mk);
                e_data = exp_row(d, mk, a, w);
                if (mk == 2*a - 2) begin e_done = 1'b1; ph = 2; end
                mk++;
            end else if (ph == 2) begin
                ph = 0;
            end else if (ph == 0 && st) begin
                ph = 1; mk = 0; mset = int'(sid);
            end
        end
        @(posedge clk);
        #1;
        if (o_we_n != 4'hF) writes++;
        chk("we_n",  512'(o_we_n),  512'(e_we_n));
        chk("waddr", 512'(o_waddr), 512'(e_addr));
        chk("wdata", o_wdata, e_data);
        chk("done",  512'(o_done),  512'(e_done));
        chk("busy",  512'(o_busy),  512'(ph != 0));
        chk("err",   512'(o_err),   512'(sel ? m_err_l : m_err_s));
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) step(1'b1, 1'b0, 2'd0, 1'b0, rnd_beat());
    endtask

    // One complete set, optionally pausing in_valid for gap_len cycles before beat gap_at.
    task automatic run_set(input logic [1:0] sid, input int gap_at, input int gap_len);
        int nb;
        nb = 2 * (sel ? LA : SA) - 1;
        step(1'b1, 1'b1, sid, 1'b0, rnd_beat());
        for (int b = 0; b < nb; b++) begin
            if (b == gap_at) idle(gap_len);
            step(1'b1, 1'b0, 2'd0, 1'b1, rnd_beat());
        end
        idle(2);
    endtask

    initial begin
        logic [31:0] lit [7];
        lit = '{32'h01000000, 32'h01020000, 32'h01020300, 32'h01020304,
                32'h02030400, 32'h03040000, 32'h04000000};
        sel = 1'b0; srstn = 1'b0; start = 1'b0; in_valid = 1'b0; set_id = '0; qd = '0;

        // Reset state
        step(1'b0, 1'b0, 2'd0, 1'b0, '0);
        step(1'b0, 1'b1, 2'd0, 1'b1, rnd_beat());
        idle(1);

        // Full set, set 0, lane i = i+1
        step(1'b1, 1'b1, 2'd0, 1'b0, '0);
        for (int b = 0; b < 7; b++) begin
            step(1'b1, 1'b0, 2'd0, 1'b1, 512'h04030201);
            chk("t1_wdata_lit", 512'(s_wdata), 512'(lit[b]));
            chk("t1_waddr_lit", 512'(s_waddr), 512'(b));
        end
        idle(2);

        // Bank wrap
        run_set(2'd2, -1, 0);
        run_set(2'd3, -1, 0);

        // Gapped input
        writes = 0;
        run_set(2'd1, 3, 3);
        chk("t3_writes", 512'(writes), 512'd7);

        // Protocol errors
        step(1'b0, 1'b0, 2'd0, 1'b0, '0);
        step(1'b1, 1'b0, 2'd0, 1'b1, rnd_beat());
        idle(1);
        step(1'b1, 1'b1, 2'd1, 1'b1, rnd_beat());
        for (int b = 0; b < 7; b++) step(1'b1, b == 2, 2'd2, 1'b1, rnd_beat());
        step(1'b1, 1'b1, 2'd0, 1'b0, rnd_beat());
        idle(2);

        // Reset mid-set, then a fresh set
        step(1'b1, 1'b1, 2'd0, 1'b0, rnd_beat());
        for (int b = 0; b < 3; b++) step(1'b1, 1'b0, 2'd0, 1'b1, rnd_beat());
        step(1'b0, 1'b0, 2'd0, 1'b1, rnd_beat());
        idle(1);
        run_set(2'd0, -1, 0);

        // Large configuration, every set_id, random data and gaps
        sel = 1'b1;
        step(1'b0, 1'b0, 2'd0, 1'b0, '0);
        for (int s = 0; s < 4; s++) begin
            writes = 0;
            run_set(2'(s), int'($urandom_range(62, 0)), int'($urandom_range(2, 0)));
            chk("t6_writes", 512'(writes), 512'd63);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
